// File: rtl/ws2812_ctrl.sv
// WS2812 single-wire serialiser: pulls 24-bit GRB pixels from the select stage one at a time
// and drives MSB-first pulse-width-coded bits, followed by a low latch gap after each frame.
module ws2812_ctrl #(
  parameter int unsigned PIX_NUM    = 64,
  parameter int unsigned T_BIT      = 63,
  parameter int unsigned T0H        = 20,
  parameter int unsigned T1H        = 40,
  parameter int unsigned RST_CYCLES = 15000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ws2812_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_start,
  output logic        dout,
  output logic        busy
);

  localparam int unsigned BW = $clog2(T_BIT + 1);
  localparam int unsigned PW = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam int unsigned GW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [BW-1:0] BitLast = BW'(T_BIT - 1);
  localparam logic [BW-1:0] Hi0     = BW'(T0H);
  localparam logic [BW-1:0] Hi1     = BW'(T1H);
  localparam logic [PW-1:0] PixLast = PW'(PIX_NUM - 1);
  localparam logic [GW-1:0] GapLast = GW'(RST_CYCLES - 1);
  localparam logic [4:0]    IdxLast = 5'd23;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          pend_q, pend_d;
  logic          dout_q, dout_d;
  logic          cfg_start_q, cfg_start_d;
  logic [BW-1:0] hi_thr;

  assign hi_thr = shreg_q[23] ? Hi1 : Hi0;

  // dout_d is the level for the counter value of the *next* cycle, so the registered
  // output lines up with the SEND counter instead of lagging it.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    pix_cnt_d   = pix_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    dout_d      = 1'b0;
    cfg_start_d = (state_q == StLoad);

    if (ws2812_start && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ws2812_start) begin
          state_d   = StLoad;
          pix_cnt_d = '0;
        end
      end
      StLoad: begin
        state_d   = StSend;
        shreg_d   = cfg_data;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        dout_d    = 1'b1;  // counter 0 is below either high time
      end
      StSend: begin
        if (bit_cnt_q == BitLast) begin
          bit_cnt_d = '0;
          shreg_d   = {shreg_q[22:0], 1'b0};
          if (bit_idx_q == IdxLast) begin
            bit_idx_d = '0;
            if (pix_cnt_q == PixLast) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end else begin
              state_d   = StLoad;
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            dout_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          dout_d    = (bit_cnt_d < hi_thr);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          // a request landing on the very last gap cycle is honoured rather than lost
          if (pend_q || ws2812_start) begin
            state_d   = StLoad;
            pix_cnt_d = '0;
            pend_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      dout_q      <= 1'b0;
      cfg_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      dout_q      <= dout_d;
      cfg_start_q <= cfg_start_d;
    end
  end

  assign dout      = dout_q;
  assign cfg_start = cfg_start_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Self-checking bench for ws2812_ctrl: a frame-timing model computes dout/cfg_start/busy for
// every cycle from the pixel period arithmetic; scaled-down parameters keep runs short.
`timescale 1ns/1ps
module tb_ws2812_ctrl;

  localparam int PIX_NUM    = 8;
  localparam int T_BIT      = 12;
  localparam int T0H        = 4;
  localparam int T1H        = 8;
  localparam int RST_CYCLES = 50;
  localparam int PP         = 1 + 24 * T_BIT;
  localparam int FRAME      = PIX_NUM * PP;
  localparam int FLEN       = FRAME + RST_CYCLES;
  localparam int MID_PIX    = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        ws2812_start = 1'b0;
  logic [23:0] cfg_data = '0;
  logic        cfg_start, dout, busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fs = -1;      // cycle of the current frame's first LOAD, -1 when idle
  bit          pend = 1'b0;
  logic [23:0] tbl [PIX_NUM];
  logic [2:0]  exp3;

  ws2812_ctrl #(
    .PIX_NUM   (PIX_NUM),
    .T_BIT     (T_BIT),
    .T0H       (T0H),
    .T1H       (T1H),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .ws2812_start(ws2812_start),
    .cfg_data    (cfg_data),
    .cfg_start   (cfg_start),
    .dout        (dout),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // {dout, cfg_start, busy} expected in cycle t
  function automatic logic [2:0] model_out(input int t);
    int o, p, r, b, c;
    logic v;
    if (fs < 0) return 3'b000;
    o = t - fs;
    if (o >= FRAME) return 3'b001;
    p = o / PP;
    r = o % PP;
    if (r == 0) return 3'b001;
    b = (r - 1) / T_BIT;
    c = (r - 1) % T_BIT;
    v = tbl[p][23 - b];
    return {(c < (v ? T1H : T0H)), (r == 1), 1'b1};
  endfunction

  // Apply inputs for one cycle, advance the model, leave exp3 for the new cycle.
  task automatic step(input logic start, input logic rst);
    int o;
    o = cyc - fs;
    if (fs >= 0 && o < FRAME && (o % PP) == 0) cfg_data = tbl[o / PP];
    else cfg_data = 24'($urandom);
    ws2812_start = start;
    sys_rst = rst;
    if (rst) begin
      fs = -1;
      pend = 1'b0;
    end else if (start) begin
      if (fs >= 0) pend = 1'b1;
      else fs = cyc + 1;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    ws2812_start = 1'b0;
    sys_rst = 1'b0;
    if (fs >= 0 && cyc - fs == FLEN) begin
      if (pend) begin
        fs = cyc;
        pend = 1'b0;
      end else begin
        fs = -1;
      end
    end
    exp3 = model_out(cyc);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i < 2);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL reset cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
    end
  endtask

  task automatic test_const();
    int load, pulses, last, fall;
    foreach (tbl[i]) tbl[i] = 24'hFF0000;
    step(1'b1, 1'b0);
    load = cyc;
    pulses = 0;
    last = -1;
    fall = -1;
    for (int i = 0; i < FLEN + 20; i++) begin
      step(1'b0, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL const_wave cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (cfg_start === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (cyc - last != PP) begin
            bad++;
            $display("FAIL const_spacing got %0d expected %0d", cyc - last, PP);
          end
        end
        pulses++;
        last = cyc;
      end
      if (busy === 1'b0 && fall < 0) fall = cyc - load;
    end
    total++;
    if (pulses != PIX_NUM) begin
      bad++;
      $display("FAIL const_pulses got %0d expected %0d", pulses, PIX_NUM);
    end
    total++;
    if (fall != FLEN) begin
      bad++;
      $display("FAIL const_busy_fall got %0d expected %0d", fall, FLEN);
    end
  endtask

  task automatic test_index();
    int hi_len, nbits;
    logic [23:0] word;
    logic [23:0] got[$];
    foreach (tbl[i]) tbl[i] = 24'(i);
    hi_len = 0;
    nbits = 0;
    word = '0;
    step(1'b1, 1'b0);
    for (int i = 0; i < FLEN + 10; i++) begin
      step(1'b0, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL index_wave cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (dout === 1'b1) begin
        hi_len++;
      end else if (hi_len > 0) begin
        word = {word[22:0], (hi_len > (T0H + T1H) / 2)};
        hi_len = 0;
        nbits++;
        if (nbits == 24) begin
          got.push_back(word);
          nbits = 0;
        end
      end
    end
    total++;
    if (got.size() != PIX_NUM) begin
      bad++;
      $display("FAIL index_count got %0d expected %0d", got.size(), PIX_NUM);
    end else begin
      for (int i = 0; i < PIX_NUM; i++) begin
        total++;
        if (got[i] !== 24'(i)) begin
          bad++;
          $display("FAIL index_decode pixel %0d got %h expected %h", i, got[i], 24'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    int load;
    logic s;
    foreach (tbl[i]) tbl[i] = 24'($urandom);
    step(1'b1, 1'b0);
    load = cyc;
    for (int i = 0; i < 3 * FLEN; i++) begin
      s = (cyc - load < FRAME) && ($urandom_range(0, 299) == 0);
      step(s, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL random_wave cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (fs < 0 && cyc - load > FLEN + 5) break;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL random_timeout busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int load, pulses;
    logic s;
    foreach (tbl[i]) tbl[i] = 24'($urandom);
    step(1'b1, 1'b0);
    load = cyc;
    pulses = 0;
    while (cyc - load < 2 * FLEN + 20) begin
      s = (cyc - load == (PIX_NUM - 1) * PP + 1) || (cyc - load == FRAME + 10) ||
          (cyc - load == FRAME + 30);
      step(s, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL b2b_wave cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (cfg_start === 1'b1) pulses++;
      if (cyc - load == FLEN) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_no_idle busy=%b expected 1", busy);
        end
      end
      if (cyc - load == FLEN + 1) begin
        total++;
        if (cfg_start !== 1'b1) begin
          bad++;
          $display("FAIL b2b_restart cfg_start=%b expected 1", cfg_start);
        end
      end
    end
    total++;
    if (pulses != 2 * PIX_NUM) begin
      bad++;
      $display("FAIL b2b_pulses got %0d expected %0d", pulses, 2 * PIX_NUM);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int load, pulses;
    foreach (tbl[i]) tbl[i] = 24'($urandom);
    step(1'b1, 1'b0);
    load = cyc;
    while (cyc - load < MID_PIX * PP + 1 + 5 * T_BIT + 2) begin
      step(1'b0, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL midrst_pre cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
    end
    step(1'b0, 1'b1);
    total++;
    if (dout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_next dout/busy=%b%b expected 00", dout, busy);
    end
    pulses = 0;
    for (int i = 0; i < 2 * PP; i++) begin
      step(1'b0, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL midrst_post cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (cfg_start === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL midrst_pulses got %0d expected 0", pulses);
    end
  endtask

  task automatic test_idle_hold();
    int load, stray;
    foreach (tbl[i]) tbl[i] = 24'($urandom);
    step(1'b1, 1'b0);
    load = cyc;
    stray = 0;
    while (cyc - load < FLEN + 3 * PP) begin
      step(1'b0, 1'b0);
      total++;
      if ({dout, cfg_start, busy} !== exp3) begin
        bad++;
        $display("FAIL idle_wave cyc=%0d dout/cfg_start/busy=%b expected %b", cyc,
                 {dout, cfg_start, busy}, exp3);
      end
      if (cyc - load >= FLEN && (dout !== 1'b0 || cfg_start !== 1'b0 || busy !== 1'b0))
        stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL idle_hold active cycles got %0d expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_index();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_idle_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
